// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, stage FSM encoding and shift-op helper.
// Also used by the ALU control decoder so both agree on the alu_ctrl encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLTU = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic is_shift(input logic [3:0] ctrl);
        return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational non-shift ALU datapath; shift codes and unused codes yield zero.
module alu_core
    import alu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] result
);

    always_comb begin
        result = '0;
        case (alu_ctrl)
            ALU_AND:  result = op_a & op_b;
            ALU_OR:   result = op_a | op_b;
            ALU_XOR:  result = op_a ^ op_b;
            ALU_ADD:  result = op_a + op_b;
            ALU_SUB:  result = op_a - op_b;
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/ex_alu_stage.sv
// Execute-stage ALU with valid/ready handshakes, output register and FSM (IDLE/SHIFT/DONE).
// Define SHIFT_FAST_EN for a single-cycle barrel shifter; otherwise shifts iterate one bit per cycle.
module ex_alu_stage
    import alu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int SW = $clog2(XLEN);

    logic [1:0]      state_reg, state_next;
    logic [XLEN-1:0] result_reg, result_next;
    logic [XLEN-1:0] core_result;
    logic [SW-1:0]   shamt;

    assign shamt = op_b[SW-1:0];

    alu_core #(.XLEN(XLEN)) u_core (
        .alu_ctrl (alu_ctrl),
        .op_a     (op_a),
        .op_b     (op_b),
        .result   (core_result)
    );

`ifdef SHIFT_FAST_EN
    logic [XLEN-1:0] barrel_result;

    always_comb begin
        barrel_result = '0;
        case (alu_ctrl)
            ALU_SLL: barrel_result = op_a << shamt;
            ALU_SRL: barrel_result = op_a >> shamt;
            ALU_SRA: barrel_result = $signed(op_a) >>> shamt;
            default: barrel_result = '0;
        endcase
    end
`else
    logic [3:0]      ctrl_reg, ctrl_next;
    logic [SW-1:0]   count_reg, count_next;
    logic [XLEN-1:0] step_result;

    // result_reg doubles as the shift accumulator while in SHIFT
    always_comb begin
        case (ctrl_reg)
            ALU_SLL: step_result = {result_reg[XLEN-2:0], 1'b0};
            ALU_SRL: step_result = {1'b0, result_reg[XLEN-1:1]};
            default: step_result = {result_reg[XLEN-1], result_reg[XLEN-1:1]};
        endcase
    end
`endif

    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
`ifndef SHIFT_FAST_EN
        ctrl_next   = ctrl_reg;
        count_next  = count_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next = ST_DONE;
                    if (is_shift(alu_ctrl)) begin
`ifdef SHIFT_FAST_EN
                        result_next = barrel_result;
`else
                        result_next = op_a;
                        ctrl_next   = alu_ctrl;
                        count_next  = shamt;
                        if (shamt != '0) begin
                            state_next = ST_SHIFT;
                        end
`endif
                    end else begin
                        result_next = core_result;
                    end
                end
            end
`ifndef SHIFT_FAST_EN
            ST_SHIFT: begin
                result_next = step_result;
                count_next  = count_reg - 1'b1;
                if (count_reg == SW'(1)) begin
                    state_next = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            result_reg <= '0;
`ifndef SHIFT_FAST_EN
            ctrl_reg   <= '0;
            count_reg  <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            result_reg <= result_next;
`ifndef SHIFT_FAST_EN
            ctrl_reg   <= ctrl_next;
            count_reg  <= count_next;
`endif
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign result    = result_reg;
    assign zero      = (result_reg == '0);

endmodule

// File: tb/tb_ex_alu_stage.sv
// Self-checking bench for ex_alu_stage: vector table driven through a scoreboard plus
// hand-written backpressure and reset-mid-shift sequences.
module tb_ex_alu_stage;

    localparam int XLEN = 64;
    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]  ctrl;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          hold;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        logic        z;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    always #5 clk = ~clk;

    ex_alu_stage #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, req);
        end
    endtask

    function automatic int exp_lat(input logic [3:0] c, input logic [63:0] b);
`ifdef SHIFT_FAST_EN
        return 1;
`else
        if (c == 4'b0100 || c == 4'b0101 || c == 4'b1001) begin
            return 1 + int'(b[5:0]);
        end
        return 1;
`endif
    endfunction

    task automatic add_vec(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] e, input int h);
        vec_t v;
        v.ctrl = c; v.a = a; v.b = b; v.exp = e; v.hold = h;
        vecs.push_back(v);
    endtask

    task automatic run_op(input vec_t v, input int idx);
        int   waitc;
        int   lat;
        exp_t e;
        logic [63:0] held;
        waitc = 0;
        while (in_ready !== 1'b1 && waitc < 300) begin
            @(negedge clk);
            waitc++;
        end
        check($sformatf("v%0d in_ready_before", idx), in_ready, 1);
        out_ready = (v.hold == 0);
        in_valid  = 1'b1;
        alu_ctrl  = v.ctrl;
        op_a      = v.a;
        op_b      = v.b;
        e.res = v.exp;
        e.z   = (v.exp == 64'd0);
        sb_q.push_back(e);
        @(negedge clk);
        // operands change after acceptance and must not disturb the stage
        in_valid = 1'b0;
        alu_ctrl = 4'b0010;
        op_a     = ~v.a;
        op_b     = ~v.b;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("v%0d latency", idx), lat, exp_lat(v.ctrl, v.b));
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL v%0d scoreboard: got empty queue expected entry", idx);
            e.res = 64'd0;
            e.z   = 1'b1;
        end else begin
            e = sb_q.pop_front();
        end
        check($sformatf("v%0d result", idx), result, e.res);
        check($sformatf("v%0d zero", idx), zero, e.z);
        check($sformatf("v%0d in_ready_done", idx), in_ready, 0);
        held = result;
        for (int k = 0; k < v.hold; k++) begin
            @(negedge clk);
            check($sformatf("v%0d hold%0d result", idx, k), result, held);
            check($sformatf("v%0d hold%0d out_valid", idx, k), out_valid, 1);
            check($sformatf("v%0d hold%0d in_ready", idx, k), in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check($sformatf("v%0d out_valid_after", idx), out_valid, 0);
        check($sformatf("v%0d in_ready_after", idx), in_ready, 1);
        $display("op %0d ctrl=%b a=0x%h b=0x%h result=0x%h zero=%b latency=%0d",
                 idx, v.ctrl, v.a, v.b, held, e.z, lat);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        add_vec(4'b0010, 64'd5,       64'd7,       64'd12, 0);
        add_vec(4'b0110, 64'h1234,    64'h1234,    64'd0,  0);
        add_vec(4'b1001, MSB,         64'd4,       64'hF800_0000_0000_0000, 0);
        add_vec(4'b1000, ALL1,        64'd1,       64'd1,  0);
        add_vec(4'b0111, ALL1,        64'd1,       64'd0,  0);
        add_vec(4'b1000, 64'd1,       ALL1,        64'd0,  0);
        add_vec(4'b0111, 64'd1,       ALL1,        64'd1,  0);
        add_vec(4'b0000, 64'hF0F0,    64'hFF00,    64'hF000, 0);
        add_vec(4'b0001, 64'hF0F0,    64'h0F0F,    64'hFFFF, 0);
        add_vec(4'b0011, 64'hFF,      64'h0F,      64'hF0, 0);
        add_vec(4'b0100, 64'd1,       64'd63,      MSB,    0);
        add_vec(4'b0101, MSB,         64'd63,      64'd1,  0);
        add_vec(4'b0101, MSB,         64'd1,       64'h4000_0000_0000_0000, 0);
        add_vec(4'b0100, 64'd3,       64'h41,      64'd6,  0);
        add_vec(4'b1001, MSB,         64'd0,       MSB,    0);
        add_vec(4'b1001, 64'h4000_0000_0000_0000, 64'd2, 64'h1000_0000_0000_0000, 0);
        add_vec(4'b0010, ALL1,        64'd1,       64'd0,  0);
        add_vec(4'b0110, 64'd0,       64'd1,       ALL1,   0);
        add_vec(4'b1010, 64'd5,       64'd7,       64'd0,  0);
        add_vec(4'b1111, 64'd5,       64'd7,       64'd0,  0);
        add_vec(4'b0010, 64'd100,     64'd23,      64'd123, 3);

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_ctrl  = 4'b0;
        op_a      = '0;
        op_b      = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset result", result, 0);
        check("reset zero", zero, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i], i);
        end

        // reset ten cycles into a 40-bit shift: in-flight op is dropped
        out_ready = 1'b0;
        in_valid  = 1'b1;
        alu_ctrl  = 4'b0100;
        op_a      = 64'd1;
        op_b      = 64'd40;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midshift in_ready", in_ready, 1);
        check("midshift out_valid", out_valid, 0);
        check("midshift result", result, 0);
        check("midshift zero", zero, 1);
        out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        check("midshift no_output", seen, 0);
        $display("op reset-mid-shift ctrl=0100 a=0x1 b=40 delivered=%0d", seen);

        vecs.delete();
        add_vec(4'b0010, 64'd5, 64'd7, 64'd12, 0);
        run_op(vecs[0], 100);

        check("scoreboard empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
